// File: rtl/car_controller_pwm_if.sv
// Drive-side signal bundle for the wheel controller: enable, sensor and speed in,
// wheel enables, PWM, state and timeout out.
interface car_controller_pwm_if #(
    parameter int PWM_W = 8
);
    logic             en;
    logic             x;
    logic [PWM_W-1:0] speed;
    logic [1:0]       z;
    logic             pwm_l;
    logic             pwm_r;
    logic [1:0]       state;
    logic             timeout;

    modport master (
        output en, x, speed,
        input  z, pwm_l, pwm_r, state, timeout
    );

    modport slave (
        input  en, x, speed,
        output z, pwm_l, pwm_r, state, timeout
    );
endinterface

// File: rtl/car_controller_pwm.sv
// Four-phase wheel controller with a synchronised, debounced steering sensor,
// turn timeout, drive enable and per-wheel PWM speed outputs.
module car_controller_pwm #(
    parameter int DEB_CYCLES   = 4,
    parameter int PWM_W        = 8,
    parameter int TURN_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    car_controller_pwm_if.slave  bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TURN_TIMEOUT + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FWD_A  = 2'b00,
        TURN_A = 2'b01,
        FWD_B  = 2'b10,
        TURN_B = 2'b11
    } state_t;

    logic [1:0]       x_sync_reg;
    logic             x_db_reg;
    logic             x_db_prev_reg;
    logic [DW-1:0]    deb_cnt_reg;
    state_t           state_reg;
    state_t           state_next;
    logic [TW-1:0]    turn_cnt_reg;
    logic             timeout_reg;
    logic             timeout_next;
    logic [1:0]       z_reg;
    logic [1:0]       z_next;
    logic [PWM_W-1:0] pc_reg;
    logic [PWM_W-1:0] speed_q_reg;
    logic [1:0]       pwm_reg;
    logic             rise;

    assign rise = x_db_reg & ~x_db_prev_reg;

    // x_sync_reg[1] is the synchronised sensor; the debouncer runs regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sync_reg    <= 2'b00;
            x_db_reg      <= 1'b0;
            x_db_prev_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            x_sync_reg    <= {x_sync_reg[0], bus.x};
            x_db_prev_reg <= x_db_reg;
            if (x_sync_reg[1] == x_db_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                x_db_reg    <= x_sync_reg[1];
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    // A released sensor beats the timeout when both land on the same cycle.
    always_comb begin
        state_next   = state_reg;
        timeout_next = 1'b0;
        if (bus.en) begin
            unique case (state_reg)
                FWD_A:  if (rise) state_next = TURN_A;
                FWD_B:  if (rise) state_next = TURN_B;
                TURN_A: begin
                    if (!x_db_reg) begin
                        state_next = FWD_B;
                    end else if (turn_cnt_reg == TURN_LAST) begin
                        state_next   = FWD_B;
                        timeout_next = 1'b1;
                    end
                end
                TURN_B: begin
                    if (!x_db_reg) begin
                        state_next = FWD_A;
                    end else if (turn_cnt_reg == TURN_LAST) begin
                        state_next   = FWD_A;
                        timeout_next = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        z_next = 2'b11;
        unique case (state_next)
            FWD_A, FWD_B: z_next = 2'b11;
            TURN_A:       z_next = 2'b01;
            TURN_B:       z_next = 2'b10;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FWD_A;
            turn_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            z_reg        <= 2'b00;
        end else begin
            state_reg   <= state_next;
            timeout_reg <= timeout_next;
            z_reg       <= bus.en ? z_next : 2'b00;
            if (state_next != state_reg) begin
                turn_cnt_reg <= '0;
            end else if (bus.en && state_reg[0]) begin
                turn_cnt_reg <= turn_cnt_reg + 1'b1;
            end
        end
    end

    // Speed is only latched at the top of a period so a change never glitches a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= '0;
            speed_q_reg <= '0;
        end else begin
            pc_reg <= pc_reg + 1'b1;
            if (pc_reg == '0) begin
                speed_q_reg <= bus.speed;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pwm
            logic pwm_bit_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pwm_bit_reg <= 1'b0;
                end else begin
                    pwm_bit_reg <= bus.en & z_next[gi] & (pc_reg < speed_q_reg);
                end
            end
            assign pwm_reg[gi] = pwm_bit_reg;
        end
    endgenerate

    assign bus.z       = z_reg;
    assign bus.state   = state_reg;
    assign bus.timeout = timeout_reg;
    assign bus.pwm_l   = pwm_reg[1];
    assign bus.pwm_r   = pwm_reg[0];
endmodule
